vga_tilegen: RTL

VGA_TILEGEN -- requirements
Module: vga_tilegen

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_timing.sv | 54 +++++
 rtl/vga_tilegen.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, pixel-format enum and total-period helpers for the
// VGA tile generator.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE  = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_ACTIVE  = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;
  localparam int unsigned DEF_TILE_LOG2 = 5;
  localparam int unsigned DEF_COLS      = 20;
  localparam int unsigned DEF_ROWS      = 15;
  localparam int unsigned DEF_BASE      = 65;
  localparam int unsigned DEF_AW        = 9;

  typedef enum logic {
    MODE_RGB222 = 1'b0,
    MODE_RGB444 = 1'b1
  } mode_e;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters with raw (unpipelined) active-area and sync decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic          sysclk,
  input  logic          reset,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          active,
  output logic          hs,
  output logic          vs
);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS      = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_VIS      = VW'(V_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_LO  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_HI  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_SYNC_LO  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_HI  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + VW'(1);
    end else begin
      hcount <= hcount + HW'(1);
    end
  end

  always_comb begin
    active = (hcount < H_VIS) && (vcount < V_VIS);
    hs     = !((hcount >= H_SYNC_LO) && (hcount <= H_SYNC_HI));
    vs     = !((vcount >= V_SYNC_LO) && (vcount <= V_SYNC_HI));
  end

endmodule

// File: rtl/vga_tilegen.sv
// Tile-mapped VGA generator: one memory word per 4 (RGB222) or 2 (RGB444)
// tiles, three-stage pipeline from raster counters to registered pins.
module vga_tilegen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter int unsigned TILE_LOG2 = DEF_TILE_LOG2,
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned BASE      = DEF_BASE,
  parameter int unsigned AW        = DEF_AW
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          mode,
  output logic [AW-1:0] vaddr,
  input  logic [31:0]   vdata,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          de,
  output logic          frame_start
);

  localparam int unsigned HW         = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int unsigned VW         = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int unsigned WORDS_BYTE = (COLS + 3) / 4;
  localparam int unsigned WORDS_HALF = (COLS + 1) / 2;

  // S0: raster position
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          raw_active;
  logic          raw_hs;
  logic          raw_vs;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .sysclk (sysclk),
    .reset  (reset),
    .hcount (hcount),
    .vcount (vcount),
    .active (raw_active),
    .hs     (raw_hs),
    .vs     (raw_vs)
  );

  logic [HW-1:0] col;
  logic [VW-1:0] row;
  logic          first;
  logic          in_grid;
  mode_e         mode_q;
  mode_e         mode_now;

  // The frame's first pixel uses the live input so the new mode applies
  // from pixel (0,0); every later pixel uses the value latched there.
  always_comb begin
    col      = hcount >> TILE_LOG2;
    row      = vcount >> TILE_LOG2;
    first    = (hcount == '0) && (vcount == '0);
    mode_now = first ? mode_e'(mode) : mode_q;
    in_grid  = raw_active && (32'(col) < COLS) && (32'(row) < ROWS);
    if (mode_now == MODE_RGB444)
      vaddr = AW'(BASE) + AW'(row * WORDS_HALF) + AW'(col >> 1);
    else
      vaddr = AW'(BASE) + AW'(row * WORDS_BYTE) + AW'(col >> 2);
  end

  // S1: memory word arrives on vdata; position info follows it here
  logic       s1_valid;
  logic       s1_active;
  logic       s1_in_grid;
  logic       s1_hs;
  logic       s1_vs;
  logic       s1_first;
  mode_e      s1_mode;
  logic [1:0] s1_sel;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      mode_q     <= MODE_RGB222;
      s1_valid   <= 1'b0;
      s1_active  <= 1'b0;
      s1_in_grid <= 1'b0;
      s1_hs      <= 1'b1;
      s1_vs      <= 1'b1;
      s1_first   <= 1'b0;
      s1_mode    <= MODE_RGB222;
      s1_sel     <= '0;
    end else begin
      if (first)
        mode_q <= mode_e'(mode);
      s1_valid   <= 1'b1;
      s1_active  <= raw_active;
      s1_in_grid <= in_grid;
      s1_hs      <= raw_hs;
      s1_vs      <= raw_vs;
      s1_first   <= first;
      s1_mode    <= mode_now;
      s1_sel     <= col[1:0];
    end
  end

  logic [5:0]  pix_byte;
  logic [11:0] pix;
  logic        unused_vdata;

  // Bits 31:30 and 15:14 are byte MSBs that RGB222 ignores and that lie
  // outside either RGB444 halfword's colour field.
  assign unused_vdata = ^{vdata[31:30], vdata[15:14]};

  always_comb begin
    pix_byte = '0;
    pix      = '0;
    unique case (s1_sel)
      2'd0: pix_byte = vdata[29:24];
      2'd1: pix_byte = vdata[21:16];
      2'd2: pix_byte = vdata[13:8];
      2'd3: pix_byte = vdata[5:0];
    endcase
    if (s1_mode == MODE_RGB444)
      pix = s1_sel[0] ? vdata[11:0] : vdata[27:16];
    else
      pix = {pix_byte[5:4], 2'b00, pix_byte[3:2], 2'b00, pix_byte[1:0], 2'b00};
  end

  // S2: registered pins
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      de          <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else if (s1_valid) begin
      vga_r       <= s1_in_grid ? pix[11:8] : '0;
      vga_g       <= s1_in_grid ? pix[7:4]  : '0;
      vga_b       <= s1_in_grid ? pix[3:0]  : '0;
      de          <= s1_active;
      vga_hs      <= s1_hs;
      vga_vs      <= s1_vs;
      frame_start <= s1_first;
    end else begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      de          <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end
  end

endmodule
